// File: rtl/ex_pkg.sv
// Shared opcodes, FSM state type and op-class helper for the execute stage.
package ex_pkg;

  localparam logic [4:0] EX_OP_ADD   = 5'b00000;
  localparam logic [4:0] EX_OP_SUB   = 5'b00001;
  localparam logic [4:0] EX_OP_AND   = 5'b00010;
  localparam logic [4:0] EX_OP_OR    = 5'b00011;
  localparam logic [4:0] EX_OP_XOR   = 5'b00100;
  localparam logic [4:0] EX_OP_SLL   = 5'b00101;
  localparam logic [4:0] EX_OP_SRL   = 5'b00110;
  localparam logic [4:0] EX_OP_SRA   = 5'b00111;
  localparam logic [4:0] EX_OP_SLT   = 5'b01000;
  localparam logic [4:0] EX_OP_SLTU  = 5'b01001;
  localparam logic [4:0] EX_OP_MUL   = 5'b10000;
  localparam logic [4:0] EX_OP_MULHU = 5'b10001;
  localparam logic [4:0] EX_OP_DIV   = 5'b10100;
  localparam logic [4:0] EX_OP_DIVU  = 5'b10101;
  localparam logic [4:0] EX_OP_REM   = 5'b10110;
  localparam logic [4:0] EX_OP_REMU  = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } ex_mc_state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {EX_OP_MUL, EX_OP_MULHU, EX_OP_DIV, EX_OP_DIVU, EX_OP_REM, EX_OP_REMU};
  endfunction

endpackage

// File: rtl/ex_stage_mc_if.sv
// Decode-side request and memory-side result handshake of the execute stage.
interface ex_stage_mc_if #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           alu_op;
  logic                 link_sel;
  logic [XLEN-1:0]      op1;
  logic [XLEN-1:0]      op2;
  logic [XLEN-1:0]      link_addr;
  logic [REGADDR_W-1:0] rd_i;
  logic                 wreg_i;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      wdata_o;
  logic [REGADDR_W-1:0] rd_o;
  logic                 wreg_o;
  logic                 busy;

  modport slave (
    input  in_valid, alu_op, link_sel, op1, op2, link_addr, rd_i, wreg_i, out_ready,
    output in_ready, out_valid, wdata_o, rd_o, wreg_o, busy
  );

  modport master (
    output in_valid, alu_op, link_sel, op1, op2, link_addr, rd_i, wreg_i, out_ready,
    input  in_ready, out_valid, wdata_o, rd_o, wreg_o, busy
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative unit: shift-add multiplier and restoring divider, one bit per cycle.
// start loads operands; done pulses during the final iteration, result is stable afterwards.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  logic              run_q, run_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic              hi_sel_q, hi_sel_d;
  logic              sgn_q, sgn_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic            sa, sb;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   mul_sum, rem_sh, diff;
  logic [XLEN-1:0] quo, rem;

  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    hi_sel_d = hi_sel_q;
    sgn_d    = sgn_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;

    sa   = op1[XLEN-1] & ~fn[0];
    sb   = op2[XLEN-1] & ~fn[0];
    mag1 = sa ? -op1 : op1;
    mag2 = sb ? -op2 : op2;

    // acc holds {hi, lo}: {product high, multiplier} or {partial remainder, quotient}
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
    rem_sh  = acc_q[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, dvs_q};

    if (start) begin
      run_d    = 1'b1;
      cnt_d    = CNT_W'(XLEN-1);
      div_d    = fn[2];
      hi_sel_d = fn[2] ? fn[1] : fn[0];
      sgn_d    = fn[2] & ~fn[0];
      qneg_d   = sa ^ sb;
      rneg_d   = sa;
      dz_d     = (op2 == '0);
      if (fn[2]) begin
        dvs_d = mag2;
        acc_d = {{XLEN{1'b0}}, mag1};
      end else begin
        dvs_d = op1;
        acc_d = {{XLEN{1'b0}}, op2};
      end
    end else if (run_q) begin
      if (div_q) begin
        if (diff[XLEN]) acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else            acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      hi_sel_q <= 1'b0;
      sgn_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      dvs_q    <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      hi_sel_q <= hi_sel_d;
      sgn_q    <= sgn_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
    end
  end

  assign done = run_q && (cnt_q == '0);
  assign quo  = acc_q[XLEN-1:0];
  assign rem  = acc_q[2*XLEN-1:XLEN];

  // signed divide-by-zero is the only case sign correction gets wrong (negative dividend)
  always_comb begin
    if (!div_q)                result = hi_sel_q ? rem : quo;
    else if (hi_sel_q)         result = (sgn_q && rneg_q) ? -rem : rem;
    else if (sgn_q && dz_q)    result = '1;
    else                       result = (sgn_q && qneg_q) ? -quo : quo;
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU, optional iterative MUL/DIV, one registered result stage.
// EX_MULDIV_EN enables the MUL/DIV family; without it those codes behave as undefined ops.
//   state | meaning
//   IDLE  | accepting ops; single-cycle results load on the accept edge
//   CALC  | ex_muldiv iterating, input held off
//   DONE  | waiting for the output register to be free, then loads the MUL/DIV result
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  ex_stage_mc_if.slave  ex
);

  localparam int SH_W = $clog2(XLEN);

  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [REGADDR_W-1:0] rd_q, rd_d;
  logic                 wreg_q, wreg_d;
  logic                 busy;

  logic [XLEN-1:0] alu_res;
  logic            alu_def;
  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] single_res;
  logic            single_w;
  logic            accept;
  logic            out_free;

  assign shamt = ex.op2[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_def = 1'b1;
    case (ex.alu_op)
      EX_OP_ADD:  alu_res = ex.op1 + ex.op2;
      EX_OP_SUB:  alu_res = ex.op1 - ex.op2;
      EX_OP_AND:  alu_res = ex.op1 & ex.op2;
      EX_OP_OR:   alu_res = ex.op1 | ex.op2;
      EX_OP_XOR:  alu_res = ex.op1 ^ ex.op2;
      EX_OP_SLL:  alu_res = ex.op1 << shamt;
      EX_OP_SRL:  alu_res = ex.op1 >> shamt;
      EX_OP_SRA:  alu_res = $signed(ex.op1) >>> shamt;
      EX_OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(ex.op1) < $signed(ex.op2))};
      EX_OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (ex.op1 < ex.op2)};
      default:    alu_def = 1'b0;
    endcase
  end

  // a link write wins over the op code, so JAL/JALR never start the iterative unit
  assign single_res = ex.link_sel ? ex.link_addr : (alu_def ? alu_res : '0);
  assign single_w   = ex.wreg_i && (ex.link_sel || alu_def);

  assign ex.in_ready = !busy && (!out_valid_q || ex.out_ready);
  assign accept      = ex.in_valid && ex.in_ready;
  assign out_free    = !out_valid_q || ex.out_ready;

`ifdef EX_MULDIV_EN
  ex_mc_state_t         state_q, state_d;
  logic [REGADDR_W-1:0] pend_rd_q, pend_rd_d;
  logic                 pend_w_q, pend_w_d;
  logic                 busy_q, busy_d;
  logic                 md_start;
  logic                 md_done;
  logic [XLEN-1:0]      md_result;

  assign md_start = accept && !ex.link_sel && is_muldiv(ex.alu_op);
  assign busy     = busy_q;

  ex_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .fn     (ex.alu_op[2:0]),
    .op1    (ex.op1),
    .op2    (ex.op2),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wreg_d      = wreg_q;
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    pend_w_d    = pend_w_q;
    if (out_valid_q && ex.out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d   = CALC;
          pend_rd_d = ex.rd_i;
          pend_w_d  = ex.wreg_i;
        end else if (accept) begin
          out_valid_d = 1'b1;
          wdata_d     = single_res;
          rd_d        = ex.rd_i;
          wreg_d      = single_w;
        end
      end
      CALC: if (md_done) state_d = DONE;
      DONE: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          wdata_d     = md_result;
          rd_d        = pend_rd_q;
          wreg_d      = pend_w_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      pend_rd_q   <= '0;
      pend_w_q    <= 1'b0;
      out_valid_q <= 1'b0;
      wdata_q     <= '0;
      rd_q        <= '0;
      wreg_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      pend_rd_q   <= pend_rd_d;
      pend_w_q    <= pend_w_d;
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wreg_q      <= wreg_d;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    out_valid_d = out_valid_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wreg_d      = wreg_q;
    if (out_valid_q && ex.out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      wdata_d     = single_res;
      rd_d        = ex.rd_i;
      wreg_d      = single_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      wdata_q     <= '0;
      rd_q        <= '0;
      wreg_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      wreg_q      <= wreg_d;
    end
  end
`endif

  assign ex.out_valid = out_valid_q;
  assign ex.wdata_o   = wdata_q;
  assign ex.rd_o      = rd_q;
  assign ex.wreg_o    = wreg_q;
  assign ex.busy      = busy;

endmodule
